// File: rtl/seq_mem_pkg.sv
// Shared types and constants for the sequence-memory game blocks.
// State encodings are fixed because currentState is exposed for debug.
package seq_mem_pkg;

  localparam int N_LIGHTS = 10;

  typedef enum logic [2:0] {
    S_IDLE         = 3'd1,
    S_WAIT_PRESS   = 3'd2,
    S_DEB_PRESS    = 3'd3,
    S_WAIT_RELEASE = 3'd4,
    S_DEB_RELEASE  = 3'd5,
    S_DONE         = 3'd6
  } state_t;

  function automatic int deb_cycles(input int freq, input int ms);
    return freq / 1000 * ms;
  endfunction

  function automatic int to_cycles(input int freq, input int s);
    return freq * s;
  endfunction

endpackage

// File: rtl/seq_input_capture_sw_sync.sv
// Two-flop synchronizer for the raw switch bank; 2-cycle latency, no backpressure.
import seq_mem_pkg::*;

module sw_sync (
  input  logic                clock,
  input  logic                reset,
  input  logic [N_LIGHTS-1:0] i_sw,
  output logic [N_LIGHTS-1:0] o_sw_s
);

  logic [N_LIGHTS-1:0] r_meta;
  logic [N_LIGHTS-1:0] r_sync;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_sw;
      r_sync <= r_meta;
    end
  end

  assign o_sw_s = r_sync;

endmodule

// File: rtl/seq_input_capture.sv
// Captures one debounced switch answer per start, compares it to the expected one-hot
// pattern and reports done/correct/timedOut; press wait is bounded by a timeout.
import seq_mem_pkg::*;

module seq_input_capture #(
  parameter int CLOCK_FREQUENCY = 50000000,
  parameter int DEBOUNCE_MS     = 10,
  parameter int TIMEOUT_S       = 5
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic [N_LIGHTS-1:0] expected,
  input  logic [N_LIGHTS-1:0] SW,
  output logic                done,
  output logic                correct,
  output logic                timedOut,
  output logic [N_LIGHTS-1:0] captured,
  output logic [2:0]          currentState
);

  localparam int DEB_CYC = deb_cycles(CLOCK_FREQUENCY, DEBOUNCE_MS);
  localparam int TO_CYC  = to_cycles(CLOCK_FREQUENCY, TIMEOUT_S);
  localparam int DEB_W   = $clog2(DEB_CYC + 1);
  localparam int TO_W    = $clog2(TO_CYC + 1);

  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYC - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TO_CYC - 1);
  localparam logic [TO_W-1:0]  TO_MAX   = TO_W'(TO_CYC);

  logic [N_LIGHTS-1:0] w_sw_s;

  state_t              r_state,     w_state_nxt;
  logic [N_LIGHTS-1:0] r_exp,       w_exp_nxt;
  logic [N_LIGHTS-1:0] r_cand,      w_cand_nxt;
  logic [N_LIGHTS-1:0] r_captured,  w_captured_nxt;
  logic [DEB_W-1:0]    r_deb_cnt,   w_deb_nxt;
  logic [TO_W-1:0]     r_to_cnt,    w_to_nxt;
  logic                r_correct,   w_correct_nxt;
  logic                r_timed_out, w_timed_out_nxt;

  logic [DEB_W-1:0]    w_deb_inc;
  logic [TO_W-1:0]     w_to_inc;
  logic                w_press_ok;

  sw_sync u_sw_sync (
    .clock  (clock),
    .reset  (reset),
    .i_sw   (SW),
    .o_sw_s (w_sw_s)
  );

  // Timeout counter saturates rather than wrapping.
  assign w_deb_inc = r_deb_cnt + DEB_W'(1);
  assign w_to_inc  = (r_to_cnt == TO_MAX) ? r_to_cnt : r_to_cnt + TO_W'(1);

  always_comb begin
    w_state_nxt     = r_state;
    w_exp_nxt       = r_exp;
    w_cand_nxt      = r_cand;
    w_captured_nxt  = r_captured;
    w_deb_nxt       = r_deb_cnt;
    w_to_nxt        = r_to_cnt;
    w_correct_nxt   = r_correct;
    w_timed_out_nxt = r_timed_out;
    w_press_ok      = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_exp_nxt       = expected;
          w_correct_nxt   = 1'b0;
          w_timed_out_nxt = 1'b0;
          w_captured_nxt  = '0;
          w_to_nxt        = '0;
          w_state_nxt     = S_WAIT_PRESS;
        end
      end

      S_WAIT_PRESS: begin
        w_to_nxt = w_to_inc;
        if (w_sw_s != '0) begin
          w_cand_nxt  = w_sw_s;
          w_deb_nxt   = '0;
          w_state_nxt = S_DEB_PRESS;
        end
        if (r_to_cnt == TO_LAST) begin
          w_timed_out_nxt = 1'b1;
          w_captured_nxt  = '0;
          w_state_nxt     = S_DONE;
        end
      end

      S_DEB_PRESS: begin
        w_to_nxt = w_to_inc;
        if (w_sw_s == '0) begin
          w_state_nxt = S_WAIT_PRESS;
        end else if (w_sw_s == r_cand) begin
          w_deb_nxt = w_deb_inc;
          if (r_deb_cnt == DEB_LAST) begin
            w_captured_nxt = r_cand;
            w_state_nxt    = S_WAIT_RELEASE;
            w_press_ok     = 1'b1;
          end
        end else begin
          w_cand_nxt = w_sw_s;
          w_deb_nxt  = '0;
        end
        // A press completing on the last allowed cycle beats the timeout.
        if (!w_press_ok && (r_to_cnt == TO_LAST)) begin
          w_timed_out_nxt = 1'b1;
          w_captured_nxt  = '0;
          w_state_nxt     = S_DONE;
        end
      end

      S_WAIT_RELEASE: begin
        if (w_sw_s == '0) begin
          w_deb_nxt   = '0;
          w_state_nxt = S_DEB_RELEASE;
        end
      end

      S_DEB_RELEASE: begin
        if (w_sw_s == '0) begin
          w_deb_nxt = w_deb_inc;
          if (r_deb_cnt == DEB_LAST) begin
            w_correct_nxt = (r_captured == r_exp);
            w_state_nxt   = S_DONE;
          end
        end else begin
          w_state_nxt = S_WAIT_RELEASE;
        end
      end

      S_DONE: begin
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_exp       <= '0;
      r_cand      <= '0;
      r_captured  <= '0;
      r_deb_cnt   <= '0;
      r_to_cnt    <= '0;
      r_correct   <= 1'b0;
      r_timed_out <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_exp       <= w_exp_nxt;
      r_cand      <= w_cand_nxt;
      r_captured  <= w_captured_nxt;
      r_deb_cnt   <= w_deb_nxt;
      r_to_cnt    <= w_to_nxt;
      r_correct   <= w_correct_nxt;
      r_timed_out <= w_timed_out_nxt;
    end
  end

  assign done         = (r_state == S_DONE);
  assign correct      = r_correct;
  assign timedOut     = r_timed_out;
  assign captured     = r_captured;
  assign currentState = r_state;

endmodule

// File: tb/tb_seq_input_capture.sv
// Bench for seq_input_capture at 1 kHz, 3 ms debounce, 1 s timeout (DEB=3, TO=1000 cycles).
// Expected results come from a window model over the synchronized switch samples.
module tb_seq_input_capture;

  localparam int DEB = 3;
  localparam int TO  = 1000;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [9:0] expected = '0;
  logic [9:0] SW = '0;
  logic       done;
  logic       correct;
  logic       timedOut;
  logic [9:0] captured;
  logic [2:0] currentState;

  int checks   = 0;
  int failures = 0;

  logic [9:0] stim_q[$];

  seq_input_capture #(
    .CLOCK_FREQUENCY (1000),
    .DEBOUNCE_MS     (3),
    .TIMEOUT_S       (1)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .expected     (expected),
    .SW           (SW),
    .done         (done),
    .correct      (correct),
    .timedOut     (timedOut),
    .captured     (captured),
    .currentState (currentState)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Switch value the capture logic sees at its k-th decision after start (2-flop delay).
  function automatic logic [9:0] samp(input int k);
    if (k < 2 || (k - 2) >= stim_q.size()) return 10'h0;
    return stim_q[k-2];
  endfunction

  function automatic bit stable_press(input int k);
    logic [9:0] v;
    if (k < DEB) return 1'b0;
    v = samp(k);
    if (v == 10'h0) return 1'b0;
    for (int i = 1; i <= DEB; i++)
      if (samp(k - i) != v) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit stable_release(input int k);
    for (int i = 0; i <= DEB; i++)
      if (samp(k - i) != 10'h0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic void model(input logic [9:0] exp_v, output int k_done,
                                output logic [9:0] cap, output logic to, output logic cor);
    int tp;
    tp = -1;
    k_done = -1;
    for (int k = DEB; k < TO; k++)
      if (tp < 0 && stable_press(k)) tp = k;
    if (tp < 0) begin
      k_done = TO - 1;
      cap = 10'h0;
      to  = 1'b1;
      cor = 1'b0;
    end else begin
      cap = samp(tp);
      to  = 1'b0;
      cor = (cap == exp_v);
      for (int k = tp + 1 + DEB; k < tp + 5000; k++)
        if (k_done < 0 && stable_release(k)) k_done = k;
    end
  endfunction

  task automatic push_n(input logic [9:0] v, input int n);
    for (int i = 0; i < n; i++) stim_q.push_back(v);
  endtask

  task automatic run_capture(input string name, input logic [9:0] exp_v, input int n_cyc,
                             input int mid_j, input logic [9:0] mid_exp, output int done_j);
    int         k_done;
    logic [9:0] e_cap;
    logic       e_to, e_cor;
    int         done_cnt;
    logic [9:0] o_cap;
    logic       o_to, o_cor;
    logic [2:0] o_st;
    done_cnt = 0;
    done_j = -1;
    o_cap = '0; o_to = 1'b0; o_cor = 1'b0; o_st = '0;
    model(exp_v, k_done, e_cap, e_to, e_cor);

    SW = 10'h0;
    expected = exp_v;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    expected = 10'($urandom);
    SW = (stim_q.size() > 0) ? stim_q[0] : 10'h0;
    for (int j = 0; j < n_cyc; j++) begin
      @(posedge clock); #1;
      if (done === 1'b1) begin
        done_cnt++;
        if (done_cnt == 1) begin
          done_j = j;
          o_cap = captured; o_to = timedOut; o_cor = correct; o_st = currentState;
        end
      end
      start = (j == mid_j);
      if (j == mid_j) expected = mid_exp;
      SW = (j + 1 < stim_q.size()) ? stim_q[j+1] : 10'h0;
    end
    start = 1'b0;
    SW = 10'h0;

    checks++;
    if (done_cnt !== 1) begin
      failures++;
      $display("FAIL %s.done_count: got %0d expected 1", name, done_cnt);
    end
    checks++;
    if (done_j !== k_done) begin
      failures++;
      $display("FAIL %s.done_cycle: got %0d expected %0d", name, done_j, k_done);
    end
    checks++;
    if (o_st !== 3'd6) begin
      failures++;
      $display("FAIL %s.state_at_done: got %0d expected 6", name, o_st);
    end
    checks++;
    if (o_cap !== e_cap) begin
      failures++;
      $display("FAIL %s.captured: got %h expected %h", name, o_cap, e_cap);
    end
    checks++;
    if (o_to !== e_to) begin
      failures++;
      $display("FAIL %s.timedOut: got %b expected %b", name, o_to, e_to);
    end
    checks++;
    if (o_cor !== e_cor) begin
      failures++;
      $display("FAIL %s.correct: got %b expected %b", name, o_cor, e_cor);
    end
    checks++;
    if (captured !== e_cap || timedOut !== e_to || correct !== e_cor) begin
      failures++;
      $display("FAIL %s.held: got cap=%h to=%b cor=%b expected cap=%h to=%b cor=%b",
               name, captured, timedOut, correct, e_cap, e_to, e_cor);
    end
    checks++;
    if (currentState !== 3'd1) begin
      failures++;
      $display("FAIL %s.final_state: got %0d expected 1", name, currentState);
    end
    repeat (3) @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if (currentState !== 3'd1) begin
      failures++;
      $display("FAIL reset.state: got %0d expected 1", currentState);
    end
    checks++;
    if ({done, correct, timedOut} !== 3'b000) begin
      failures++;
      $display("FAIL reset.flags: got %b expected 000", {done, correct, timedOut});
    end
    checks++;
    if (captured !== 10'h0) begin
      failures++;
      $display("FAIL reset.captured: got %h expected 000", captured);
    end
    reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
  endtask

  task automatic test_correct();
    int dj;
    stim_q.delete();
    push_n(10'h004, 10);
    push_n(10'h000, 20);
    run_capture("correct", 10'h004, 30, -1, 10'h0, dj);
    // SW falls after loop edge 9; done must be visible 6 edges later.
    checks++;
    if (dj !== 15) begin
      failures++;
      $display("FAIL correct.release_latency: got done_j %0d expected 15", dj);
    end
  endtask

  task automatic test_wrong();
    int dj;
    stim_q.delete();
    push_n(10'h100, 8);
    push_n(10'h000, 15);
    run_capture("wrong", 10'h004, 25, -1, 10'h0, dj);
  endtask

  task automatic test_multi_hot();
    int dj;
    stim_q.delete();
    push_n(10'h005, 8);
    push_n(10'h000, 15);
    run_capture("multi_hot", 10'h004, 25, -1, 10'h0, dj);
  endtask

  task automatic test_bounce();
    int dj;
    stim_q.delete();
    for (int i = 0; i < 8; i++) stim_q.push_back((i % 2 == 0) ? 10'h004 : 10'h000);
    push_n(10'h004, 10);
    for (int i = 0; i < 8; i++) stim_q.push_back((i % 2 == 0) ? 10'h000 : 10'h004);
    push_n(10'h000, 15);
    run_capture("bounce", 10'h004, 45, -1, 10'h0, dj);
  endtask

  task automatic test_second_start();
    int dj;
    stim_q.delete();
    push_n(10'h004, 12);
    push_n(10'h000, 15);
    run_capture("second_start", 10'h004, 30, 3, 10'h100, dj);
  endtask

  task automatic test_timeout();
    int dj;
    stim_q.delete();
    push_n(10'h000, 1050);
    push_n(10'h004, 40);
    run_capture("timeout", 10'h004, 1100, -1, 10'h0, dj);
  endtask

  task automatic test_reset_mid();
    int done_cnt;
    done_cnt = 0;
    SW = 10'h0;
    expected = 10'h004;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    SW = 10'h004;
    for (int j = 0; j < 10; j++) begin
      @(posedge clock); #1;
      if (done === 1'b1) done_cnt++;
    end
    checks++;
    if (currentState !== 3'd4) begin
      failures++;
      $display("FAIL reset_mid.pre_state: got %0d expected 4", currentState);
    end
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    checks++;
    if (currentState !== 3'd1) begin
      failures++;
      $display("FAIL reset_mid.state: got %0d expected 1", currentState);
    end
    checks++;
    if ({done, correct, timedOut} !== 3'b000 || captured !== 10'h0) begin
      failures++;
      $display("FAIL reset_mid.outputs: got flags=%b cap=%h expected flags=000 cap=000",
               {done, correct, timedOut}, captured);
    end
    SW = 10'h0;
    for (int j = 0; j < 12; j++) begin
      @(posedge clock); #1;
      if (done === 1'b1) done_cnt++;
    end
    checks++;
    if (done_cnt !== 0) begin
      failures++;
      $display("FAIL reset_mid.no_done: got %0d pulses expected 0", done_cnt);
    end
  endtask

  function automatic logic [9:0] rand_nz();
    logic [9:0] v;
    v = 10'($urandom);
    if (v == 10'h0) v = 10'h001;
    return v;
  endfunction

  task automatic test_random();
    int         dj;
    logic [9:0] exp_v, pv, v;
    for (int it = 0; it < 8; it++) begin
      stim_q.delete();
      exp_v = (it == 7) ? 10'h0 : (10'h001 << $urandom_range(0, 9));
      for (int i = 0; i < int'($urandom_range(0, 8)); i++) begin
        case ($urandom_range(0, 2))
          0:       v = 10'h0;
          1:       v = (exp_v != 10'h0) ? exp_v : rand_nz();
          default: v = rand_nz();
        endcase
        stim_q.push_back(v);
      end
      pv = ($urandom_range(0, 1) == 1 && exp_v != 10'h0) ? exp_v : rand_nz();
      push_n(pv, $urandom_range(4, 10));
      for (int i = 0; i < int'($urandom_range(0, 6)); i++) begin
        case ($urandom_range(0, 2))
          0:       v = 10'h0;
          1:       v = pv;
          default: v = rand_nz();
        endcase
        stim_q.push_back(v);
      end
      push_n(10'h000, 12);
      run_capture($sformatf("random%0d", it), exp_v, stim_q.size() + 8, -1, 10'h0, dj);
    end
  endtask

  initial begin
    test_reset();
    test_correct();
    test_wrong();
    test_multi_hot();
    test_bounce();
    test_second_start();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
